// File: rtl/rvseed_defines.sv
// Shared definitions for the MEM stage: funct3 codes, register width, FSM encodings.
// Also holds the captured-op record and the size helpers used for alignment.
package rvseed_defines;

   localparam int DATA_W         = 64;
   localparam int REG_ADDR_WIDTH = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   // Store size comes from funct3[1:0] only.
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic                      is_load;
      logic                      is_store;
      logic [2:0]                funct3;
      logic [DATA_W-1:0]         addr;
      logic [DATA_W-1:0]         wdata;
      logic                      reg_wen;
      logic [REG_ADDR_WIDTH-1:0] reg_waddr;
      logic [DATA_W-1:0]         pc;
      logic                      ebreak;
   } op_t;

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         SZ_H:    return off[0];
         SZ_W:    return |off[1:0];
         SZ_D:    return |off;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_B:    return 8'h01;
         SZ_H:    return 8'h03;
         SZ_W:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/load_align_ext.sv
// Shifts the addressed lanes of a read beat down to bit 0, truncates to size, extends per funct3.
// Purely combinational; no latency, no flow control.
module load_align_ext
   import rvseed_defines::*;
(
   input  logic [DATA_W-1:0] rdata,
   input  logic [2:0]        offset,
   input  logic [2:0]        funct3,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] sh;

   always_comb begin
      sh = rdata >> {offset, 3'b000};
      case (funct3)
         F3_LB:   data = {{56{sh[7]}}, sh[7:0]};
         F3_LH:   data = {{48{sh[15]}}, sh[15:0]};
         F3_LW:   data = {{32{sh[31]}}, sh[31:0]};
         F3_LBU:  data = {56'd0, sh[7:0]};
         F3_LHU:  data = {48'd0, sh[15:0]};
         F3_LWU:  data = {32'd0, sh[31:0]};
         default: data = sh;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs loads/stores on a req/gnt + rvalid port; non-memory ops pass through same cycle.
// Latency 0 for pass-through, granted stores and misaligned ops; otherwise stalls upstream until done or timeout.
module mem_access_unit
   import rvseed_defines::*;
#(
   parameter int XLEN    = DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid_i,
   input  logic                      is_load_i,
   input  logic                      is_store_i,
   input  logic [2:0]                funct3_i,
   input  logic [XLEN-1:0]           alu_res_i,
   input  logic [XLEN-1:0]           store_data_i,
   input  logic                      reg_wen_i,
   input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
   input  logic [XLEN-1:0]           pc_i,
   input  logic                      ebreak_i,
   output logic                      dmem_req_o,
   output logic                      dmem_we_o,
   output logic [XLEN-1:0]           dmem_addr_o,
   output logic [XLEN-1:0]           dmem_wdata_o,
   output logic [7:0]                dmem_wmask_o,
   input  logic                      dmem_gnt_i,
   input  logic                      dmem_rvalid_i,
   input  logic [XLEN-1:0]           dmem_rdata_i,
   output logic                      mem_stall_o,
   output logic                      wb_valid_o,
   output logic                      reg_wen_o,
   output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o,
   output logic [XLEN-1:0]           from_ex_alu_res_o,
   output logic [XLEN-1:0]           from_mem_alu_res_o,
   output logic [XLEN-1:0]           pc_o,
   output logic                      ebreak_o,
   output logic                      err_o
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   logic [1:0]      state, state_nxt;
   op_t             op_q, op_in, cur;
   logic [7:0]      cnt_q;
   logic [XLEN-1:0] ld_data;
   logic [2:0]      off;
   logic            mem_op_in, timeout;
   logic            req, wb, err, stall, ld_done;

   assign op_in = '{is_load: is_load_i, is_store: is_store_i, funct3: funct3_i,
                    addr: alu_res_i, wdata: store_data_i, reg_wen: reg_wen_i,
                    reg_waddr: reg_waddr_i, pc: pc_i, ebreak: ebreak_i};

   assign mem_op_in = in_valid_i && (is_load_i || is_store_i);
   // In IDLE the op is served straight from the inputs; afterwards from the capture register.
   assign cur       = (state == ST_IDLE) ? op_in : op_q;
   assign off       = cur.addr[2:0];
   assign timeout   = (cnt_q == TIMEOUT_CNT);

   load_align_ext u_load_align_ext (
      .rdata  (dmem_rdata_i),
      .offset (off),
      .funct3 (cur.funct3),
      .data   (ld_data)
   );

   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      wb        = 1'b0;
      err       = 1'b0;
      stall     = 1'b0;
      ld_done   = 1'b0;
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               if (in_valid_i) begin
                  if (!mem_op_in) begin
                     wb = 1'b1;
                  end else if (misaligned(cur.funct3[1:0], off)) begin
                     wb  = 1'b1;
                     err = 1'b1;
                  end else begin
                     req = 1'b1;
                     if (dmem_gnt_i && cur.is_store) begin
                        wb = 1'b1;
                     end else begin
                        stall     = 1'b1;
                        state_nxt = dmem_gnt_i ? ST_RESP : ST_REQ;
                     end
                  end
               end
            end
            ST_REQ: begin
               req = 1'b1;
               if (dmem_gnt_i) begin
                  if (cur.is_store) begin
                     wb        = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     stall     = 1'b1;
                     state_nxt = ST_RESP;
                  end
               end else if (timeout) begin
                  wb        = 1'b1;
                  err       = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  stall = 1'b1;
               end
            end
            ST_RESP: begin
               if (dmem_rvalid_i) begin
                  wb        = 1'b1;
                  ld_done   = 1'b1;
                  state_nxt = ST_IDLE;
               end else if (timeout) begin
                  wb        = 1'b1;
                  err       = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  stall = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign dmem_req_o   = req;
   assign dmem_we_o    = req & cur.is_store;
   assign dmem_addr_o  = req ? {cur.addr[XLEN-1:3], 3'b000} : '0;
   assign dmem_wdata_o = req ? (cur.wdata << {off, 3'b000}) : '0;
   assign dmem_wmask_o = req ? (size_mask(cur.funct3[1:0]) << off) : 8'h00;

   // Outputs toward mem_wb_regs are zeroed whenever no beat is presented.
   assign mem_stall_o        = stall;
   assign wb_valid_o         = wb;
   assign err_o              = err;
   assign reg_wen_o          = wb & cur.reg_wen & ~err;
   assign reg_waddr_o        = wb ? cur.reg_waddr : '0;
   assign from_ex_alu_res_o  = wb ? cur.addr : '0;
   assign from_mem_alu_res_o = ld_done ? ld_data : '0;
   assign pc_o               = wb ? cur.pc : '0;
   assign ebreak_o           = wb & cur.ebreak;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         op_q  <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && mem_op_in) op_q <= op_in;
         if (state_nxt != state)      cnt_q <= '0;
         else if (state != ST_IDLE)   cnt_q <= cnt_q + 8'd1;
      end
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM stage of the NPC pipeline. It sits between the EX/MEM registers and mem_wb_regs, and executes loads and stores against a request/response data-memory port. It aligns store data and byte masks, and sign- or zero-extends load data. It stalls upstream until each access completes, then presents one result beat to mem_wb_regs. Non-memory ops pass through combinationally in the same cycle.

Parameters:
XLEN, 64, datapath width
TIMEOUT, 255, cycles without gnt or rvalid before a bus error; counter is 8 bits

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
in_valid_i  input  1  EX/MEM holds a valid instruction
is_load_i  input  1  load op
is_store_i  input  1  store op
funct3_i  input  3  size/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores use [1:0]
alu_res_i  input  64  effective address or ALU result
store_data_i  input  64  rs2 value
reg_wen_i  input  1  register write enable
reg_waddr_i  input  5  destination register
pc_i  input  64  instruction PC
ebreak_i  input  1  ebreak marker
dmem_req_o  output  1  memory request
dmem_we_o  output  1  write request
dmem_addr_o  output  64  address aligned to 8 bytes
dmem_wdata_o  output  64  store data shifted into byte lanes
dmem_wmask_o  output  8  byte-lane mask
dmem_gnt_i  input  1  request accepted this cycle
dmem_rvalid_i  input  1  read data valid
dmem_rdata_i  input  64  read data
mem_stall_o  output  1  hold IF/ID/EX and EX/MEM
wb_valid_o  output  1  result beat to mem_wb_regs
reg_wen_o  output  1  reg_wen_i gated by wb_valid_o
reg_waddr_o  output  5  destination register
from_ex_alu_res_o  output  64  ALU result
from_mem_alu_res_o  output  64  extended load data; 0 for non-loads
pc_o  output  64  PC
ebreak_o  output  1  ebreak
err_o  output  1  one-cycle pulse on misalign or timeout

Behaviour:
- While rst is high: state is IDLE, the capture register and counter are 0, and every output is 0.
- States: IDLE, REQ, RESP.
- IDLE, in_valid_i with no memory op: all outputs are driven combinationally from the inputs with wb_valid_o=1. No stall.
- IDLE, memory op: capture all inputs into the op register.
  - Misaligned access (LH/SH addr[0]≠0, W addr[1:0]≠0, D addr[2:0]≠0): no request is issued. err_o=1, wb_valid_o=1, reg_wen_o=0, no stall.
  - Otherwise: dmem_req_o=1 in the same cycle, driven from the inputs.
  - gnt in the same cycle: a store completes (wb_valid_o=1, no stall); a load moves to RESP with stall=1.
  - No gnt: move to REQ with stall=1.
- REQ: dmem_req_o=1, driven from the captured op. On gnt, a store completes and returns to IDLE; a load moves to RESP. Stall is 1 except in the cycle a store completes.
- RESP: on dmem_rvalid_i, wb_valid_o=1 with the extended load data, stall drops, and the state returns to IDLE.
- Stall rule: mem_stall_o=1 exactly in the cycles where a memory op is accepted or pending and wb_valid_o=0.
- Alignment:
  - Lane offset is addr[2:0].
  - wdata is store_data shifted left by offset×8.
  - wmask is (1, 3, 0x0F, 0xFF) shifted left by offset.
  - Load data is rdata shifted right by offset×8, truncated to size, then extended per funct3.
- Timeout: the counter clears on entry to REQ or RESP and increments each waiting cycle. On reaching TIMEOUT: err_o=1, wb_valid_o=1, reg_wen_o=0, return to IDLE. A late rvalid or gnt arriving in IDLE is ignored.
- Simultaneous gnt and rvalid in REQ: rvalid is ignored; the memory must answer at least one cycle after gnt.
- When wb_valid_o=0, all outputs except the dmem_* and mem_stall_o ports are 0, so mem_wb_regs captures a bubble.
- Reset asserted mid-access abandons the access with no further request; the memory side is reset with it.

Decomposition:
- Shared package rvseed_defines: the funct3 load/store codes, REG_ADDR_WIDTH, and the state encodings.
- One sub-module, load_align_ext: purely combinational. Inputs are rdata, offset and funct3; output is the extended 64-bit value. It is unit-tested on its own.

Test Plan:
1. ADD pass-through, alu_res=0x1234 → same cycle: wb_valid_o=1, from_ex_alu_res_o=0x1234, from_mem_alu_res_o=0, stall 0.
2. SB addr=0x80000003, data=0xAB, gnt same cycle → dmem_addr=0x80000000, wmask=0x08, wdata[31:24]=0xAB, no stall, wb_valid_o=1.
3. LB addr=0x80000005, gnt after 2 cycles, rdata=0x0000_8000_0000_0000 with lane 5 = 0x80 → stall for 4 cycles, then from_mem_alu_res_o=0xFFFF_FFFF_FFFF_FF80; the LBU variant returns 0x80.
4. LW addr=0x80000002 (misaligned) → no dmem_req_o, err_o pulse, reg_wen_o=0, no stall.
5. LD with rvalid never arriving, TIMEOUT=4 → err_o after 4 wait cycles in RESP, state returns to IDLE, the next ADD passes through.
6. rst asserted while in RESP → outputs 0 immediately; after release, dmem_req_o=0 and the state is IDLE.
